// File: rtl/dac_pkg.sv
// Shared constants, FSM state type and helpers for the DAC SPI updater.
package dac_pkg;

  localparam logic [3:0]  CMD_WRITE_UPD = 4'h3;
  localparam logic [3:0]  CMD_INTREF    = 4'h8;
  localparam int unsigned FRAME_BITS    = 24;
  localparam int unsigned NUM_CH        = 8;
  localparam logic [23:0] INTREF_FRAME  = {CMD_INTREF, 20'h00001};

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, GAP} state_t;

  // Round-robin pick: first pending channel at or after base, wrapping 7->0.
  function automatic logic [2:0] rr_pick(input logic [7:0] pend, input logic [2:0] base);
    logic [2:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = base + 3'(i);
      if (!found && pend[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [23:0] make_frame(input logic [2:0] ch, input logic [15:0] data);
    return {CMD_WRITE_UPD, 1'b0, ch, data};
  endfunction

endpackage

// File: rtl/dac_spi_updater_if.sv
// 3-wire SPI link to the serial DAC.
interface dac_spi_updater_if;
  logic dac_sclk;
  logic dac_sync_n;
  logic dac_din;

  modport master (output dac_sclk, output dac_sync_n, output dac_din);
  modport slave  (input  dac_sclk, input  dac_sync_n, input  dac_din);
endinterface

// File: rtl/dac_spi_updater_tick_gen.sv
// SCLK half-period divider: one-clk tick every CLK_DIV enabled cycles.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/dac_spi_updater.sv
// Sends changed DAC channel values over SPI, round-robin.
// Optional DAC_INTREF_EN: send the internal-reference setup frame after every reset.
module dac_spi_updater
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        cntr0,
  input  logic [15:0]        cntr1,
  input  logic [15:0]        cntr2,
  input  logic [15:0]        cntr3,
  input  logic [15:0]        cntr4,
  input  logic [15:0]        cntr5,
  input  logic [15:0]        cntr6,
  input  logic [15:0]        cntr7,
  input  logic               force_all,
  dac_spi_updater_if.master  spi,
  output logic               busy,
  output logic [2:0]         cur_ch
);
  localparam int unsigned GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

`ifdef DAC_INTREF_EN
  localparam state_t RST_STATE = SETUP;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  logic [15:0]    cntr   [NUM_CH];
  logic [15:0]    shadow [NUM_CH];
  logic [7:0]     pending, pending_nxt;
  logic [2:0]     rr_base, pick;
  state_t         state, state_nxt;
  logic [23:0]    sreg;
  logic           sclk, sync_n;
  logic [5:0]     edge_cnt;
  logic [GCW-1:0] gap_cnt;
  logic           tick, last_edge, gap_done;

  assign cntr[0] = cntr0;
  assign cntr[1] = cntr1;
  assign cntr[2] = cntr2;
  assign cntr[3] = cntr3;
  assign cntr[4] = cntr4;
  assign cntr[5] = cntr5;
  assign cntr[6] = cntr6;
  assign cntr[7] = cntr7;

  assign pick      = rr_pick(pending, rr_base);
  assign last_edge = tick && (edge_cnt == 6'(2 * FRAME_BITS - 1));
  assign gap_done  = (gap_cnt == GCW'(GAP_CYCLES - 1));

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state == SHIFT),
    .clr  (state == LOAD || state == SETUP),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:        if (pending != '0) state_nxt = LOAD;
      SETUP, LOAD: state_nxt = SHIFT;
      SHIFT:       if (last_edge) state_nxt = GAP;
      GAP:         if (gap_done) state_nxt = (pending != '0) ? LOAD : IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Clear of the loaded channel beats its own diff (shadow takes the snapshot);
  // force_all beats the clear so the current channel is resent.
  always_comb begin
    pending_nxt = pending;
    for (int unsigned n = 0; n < NUM_CH; n++)
      if (cntr[n] != shadow[n]) pending_nxt[n] = 1'b1;
    if (state == LOAD) pending_nxt[pick] = 1'b0;
    if (force_all) pending_nxt = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk     <= 1'b1;
      sync_n   <= 1'b1;
      sreg     <= '0;
      busy     <= 1'b0;
      cur_ch   <= '0;
      rr_base  <= '0;
      edge_cnt <= '0;
      gap_cnt  <= '0;
      pending  <= '1;
      for (int unsigned n = 0; n < NUM_CH; n++) shadow[n] <= '0;
    end else begin
      pending <= pending_nxt;
      case (state)
        SETUP: begin
          sreg     <= INTREF_FRAME;
          sync_n   <= 1'b0;
          busy     <= 1'b1;
          cur_ch   <= '0;
          edge_cnt <= '0;
        end
        LOAD: begin
          sreg         <= make_frame(pick, cntr[pick]);
          shadow[pick] <= cntr[pick];
          cur_ch       <= pick;
          rr_base      <= pick + 3'd1;
          sync_n       <= 1'b0;
          busy         <= 1'b1;
          edge_cnt     <= '0;
        end
        SHIFT: begin
          if (tick) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 6'd1;
            // Data advances on the rising SCLK edge; the DAC samples on falling edges.
            if (!sclk) sreg <= {sreg[FRAME_BITS-2:0], 1'b0};
            if (last_edge) begin
              sync_n  <= 1'b1;
              gap_cnt <= '0;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_done && pending == '0) busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign spi.dac_sclk   = sclk;
  assign spi.dac_sync_n = sync_n;
  assign spi.dac_din    = sreg[FRAME_BITS-1];
endmodule

// File: tb/tb_dac_spi_updater.sv
// Self-checking bench for dac_spi_updater: decodes SPI frames and compares against hand-computed words.
module tb_dac_spi_updater;
  localparam int unsigned CLK_DIV    = 3;
  localparam int unsigned GAP_CYCLES = 5;
  localparam int unsigned FRAME_CLKS = 48 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        force_all = 1'b0;
  logic [15:0] c [8];
  logic        busy;
  logic [2:0]  cur_ch;

  dac_spi_updater_if spi ();

  dac_spi_updater #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .cntr0     (c[0]),
    .cntr1     (c[1]),
    .cntr2     (c[2]),
    .cntr3     (c[3]),
    .cntr4     (c[4]),
    .cntr5     (c[5]),
    .cntr6     (c[6]),
    .cntr7     (c[7]),
    .force_all (force_all),
    .spi       (spi),
    .busy      (busy),
    .cur_ch    (cur_ch)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [23:0] data;
    int unsigned bits;
    int unsigned low_len;
    int unsigned gap;
    logic        period_ok;
  } frame_t;

  frame_t      fq[$];
  logic [23:0] m_sh;
  int unsigned m_nb, m_low, m_high, m_gap, m_last_fall, m_cyc;
  logic        m_pok, m_prev_sclk, m_prev_sync;

  // Frame decoder: samples on the DAC's falling SCLK edges.
  initial begin
    m_cyc = 0; m_nb = 0; m_low = 0; m_high = 0; m_gap = 0; m_last_fall = 0;
    m_sh = '0; m_pok = 1'b1; m_prev_sclk = 1'b1; m_prev_sync = 1'b1;
    forever begin
      @(negedge clk);
      m_cyc++;
      if (rst) begin
        m_nb = 0; m_low = 0; m_high = 0; m_pok = 1'b1;
        m_prev_sclk = 1'b1; m_prev_sync = 1'b1;
      end else begin
        if (m_prev_sync && !spi.dac_sync_n) begin
          m_nb = 0; m_low = 0; m_pok = 1'b1; m_sh = '0; m_gap = m_high;
        end
        if (!spi.dac_sync_n) begin
          m_low++;
          m_high = 0;
          if (m_prev_sclk && !spi.dac_sclk) begin
            m_sh = {m_sh[22:0], spi.dac_din};
            if (m_nb > 0 && (m_cyc - m_last_fall) != 2 * CLK_DIV) m_pok = 1'b0;
            m_last_fall = m_cyc;
            m_nb++;
          end
        end else begin
          if (!m_prev_sync)
            fq.push_back('{data: m_sh, bits: m_nb, low_len: m_low, gap: m_gap, period_ok: m_pok});
          m_high++;
        end
        m_prev_sclk = spi.dac_sclk;
        m_prev_sync = spi.dac_sync_n;
      end
    end
  end

  function automatic logic [23:0] exp_frame(input logic [2:0] ch, input logic [15:0] v);
    return {4'h3, 1'b0, ch, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input string name, input logic [23:0] exp, input bit chk_gap);
    int unsigned n = 0;
    frame_t f;
    while (fq.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (fq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no frame within cycle budget, expected %h", name, exp);
      return;
    end
    f = fq.pop_front();
    check(name, 32'(f.data), 32'(exp));
    check({name, "_bits"}, f.bits, 24);
    check({name, "_len"}, f.low_len, FRAME_CLKS);
    check({name, "_sclk_period"}, 32'(f.period_ok), 1);
    if (chk_gap) check({name, "_gap"}, f.gap, GAP_CYCLES + 1);
  endtask

  // Idle means busy low for three consecutive samples (longer than IDLE+LOAD).
  task automatic wait_idle(input string name);
    int unsigned n = 0, lo = 0;
    while (lo < 3 && n < 5000) begin
      @(negedge clk);
      n++;
      lo = busy ? 0 : lo + 1;
    end
    if (lo < 3) begin
      checks++;
      errors++;
      $display("FAIL %s: busy still high after budget, got %b expected 0", name, busy);
    end
  endtask

  task automatic wait_sync_low(input string name);
    int unsigned n = 0;
    while (spi.dac_sync_n && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (spi.dac_sync_n) begin
      checks++;
      errors++;
      $display("FAIL %s: sync_n never fell, got 1 expected 0", name);
    end
  endtask

  task automatic expect_reload(input string name);
    bit first = 1'b1;
`ifdef DAC_INTREF_EN
    expect_frame({name, "_intref"}, 24'h800001, 1'b0);
    first = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      expect_frame($sformatf("%s_ch%0d", name, i), exp_frame(3'(i), c[i]), !first);
      first = 1'b0;
    end
  endtask

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] val;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{ch: 3'd2, val: 16'h0052, exp: 24'h320052};
    vecs[1] = '{ch: 3'd7, val: 16'hFFFF, exp: 24'h37FFFF};
    vecs[2] = '{ch: 3'd7, val: 16'h0000, exp: 24'h370000};
    vecs[3] = '{ch: 3'd0, val: 16'h1234, exp: 24'h301234};
    vecs[4] = '{ch: 3'd4, val: 16'h8001, exp: 24'h348001};
    vecs[5] = '{ch: 3'd6, val: 16'h00FF, exp: 24'h3600FF};

    c[0] = 16'h0066; c[1] = 16'h0033; c[2] = 16'h0051; c[3] = 16'h0033;
    for (int i = 4; i < 8; i++) c[i] = 16'h0000;

    // Reset state and full load after reset.
    repeat (4) @(negedge clk);
    check("rst_sclk", 32'(spi.dac_sclk), 1);
    check("rst_sync_n", 32'(spi.dac_sync_n), 1);
    check("rst_din", 32'(spi.dac_din), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cur_ch", 32'(cur_ch), 0);
    rst = 1'b0;
`ifdef DAC_INTREF_EN
    expect_frame("boot_intref", 24'h800001, 1'b0);
    expect_frame("boot_ch0", 24'h300066, 1'b1);
`else
    expect_frame("boot_ch0", 24'h300066, 1'b0);
`endif
    expect_frame("boot_ch1", 24'h310033, 1'b1);
    expect_frame("boot_ch2", 24'h320051, 1'b1);
    expect_frame("boot_ch3", 24'h330033, 1'b1);
    expect_frame("boot_ch4", 24'h340000, 1'b1);
    expect_frame("boot_ch5", 24'h350000, 1'b1);
    expect_frame("boot_ch6", 24'h360000, 1'b1);
    expect_frame("boot_ch7", 24'h370000, 1'b1);
    wait_idle("boot_idle");
    check("boot_busy", 32'(busy), 0);
    check("boot_cur_ch", 32'(cur_ch), 7);
    check("boot_extra", fq.size(), 0);

    // Single-channel updates from idle.
    for (int i = 0; i < 6; i++) begin
      c[vecs[i].ch] = vecs[i].val;
      expect_frame($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
      wait_idle($sformatf("vec%0d_idle", i));
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d_cur_ch", i), 32'(cur_ch), 32'(vecs[i].ch));
      check($sformatf("vec%0d_extra", i), fq.size(), 0);
    end

    // Wrap order from cur_ch=3: ch5 before ch1.
    c[3] = 16'h0034;
    expect_frame("rr_setup", 24'h330034, 1'b0);
    wait_idle("rr_setup_idle");
    check("rr_cur_ch", 32'(cur_ch), 3);
    c[5] = 16'h5555;
    c[1] = 16'h1111;
    expect_frame("rr_first", 24'h355555, 1'b0);
    expect_frame("rr_second", 24'h311111, 1'b1);
    wait_idle("rr_idle");

    // Value change during SHIFT: snapshot completes, then new value follows.
    c[4] = 16'h4444;
    wait_sync_low("mid_sync");
    repeat (10) @(negedge clk);
    c[4] = 16'h4445;
    expect_frame("mid_old", 24'h344444, 1'b0);
    expect_frame("mid_new", 24'h344445, 1'b1);
    wait_idle("mid_idle");
    check("mid_cur_ch", 32'(cur_ch), 4);
    check("mid_extra", fq.size(), 0);

    // force_all mid-frame: all 8 resent starting after the current channel.
    c[2] = 16'h2222;
    wait_sync_low("force_sync");
    repeat (20) @(negedge clk);
    force_all = 1'b1;
    @(negedge clk);
    force_all = 1'b0;
    expect_frame("force_cur", 24'h322222, 1'b0);
    for (int k = 0; k < 8; k++)
      expect_frame($sformatf("force_ch%0d", (k + 3) % 8), exp_frame(3'((k + 3) % 8), c[(k + 3) % 8]), 1'b1);
    wait_idle("force_idle");
    check("force_extra", fq.size(), 0);

    // Reset at bit 12 of a frame aborts it and triggers a full reload.
    c[1] = 16'h0101;
    wait_sync_low("rst_sync");
    begin
      int unsigned n = 0;
      while (m_nb < 12 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("rst_reach_bit12", m_nb, 12);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_sync_n", 32'(spi.dac_sync_n), 1);
    check("abort_sclk", 32'(spi.dac_sclk), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_cur_ch", 32'(cur_ch), 0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_no_partial", fq.size(), 0);
    expect_reload("reload");
    wait_idle("reload_idle");
    check("reload_extra", fq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
